// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] PCSRC_BRANCH    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StLoadStall = 2'b01,
    StMduBusy   = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [1:0]        ResultSrcE;
  logic              MduStartE;
  logic [1:0]        PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic              MemReqM, MemReadyM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MduBusy;

  // Datapath side.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MduStartE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, MduBusy
  );

  // Hazard controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MduStartE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, MduBusy
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage operand; M result beats W result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  // x0 is hardwired zero, so it is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (reg_write_m && (rs == rd_m)) begin
        sel = FWD_M;
      end else if (reg_write_w && (rs == rd_w)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubbles, MDU occupancy,
// branch/jump flush and whole-pipeline freeze while data memory is not ready.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MDU_LATENCY  = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CntMax = (LOAD_BUBBLES > MDU_LATENCY) ? LOAD_BUBBLES : MDU_LATENCY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // The detection cycle is itself one stall cycle, hence the -2.
  localparam logic [CntW-1:0] LoadInit = CntW'((LOAD_BUBBLES > 1) ? LOAD_BUBBLES - 2 : 0);
  localparam logic [CntW-1:0] MduInit  = CntW'((MDU_LATENCY > 1) ? MDU_LATENCY - 2 : 0);

  hz_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic     mem_wait, branch_taken, load_use;
  logic     stall_f, stall_d, stall_e, stall_m;
  logic     flush_d, flush_e, flush_m, flush_w;
  logic     mdu_busy;
  fwd_sel_t fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (hz.Rs1E),
    .rd_m        (hz.RdM),
    .reg_write_m (hz.RegWriteM),
    .rd_w        (hz.RdW),
    .reg_write_w (hz.RegWriteW),
    .sel         (fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (hz.Rs2E),
    .rd_m        (hz.RdM),
    .reg_write_m (hz.RegWriteM),
    .rd_w        (hz.RdW),
    .reg_write_w (hz.RegWriteW),
    .sel         (fwd_b)
  );

  // Hazard condition decode.
  always_comb begin
    mem_wait     = hz.MemReqM && !hz.MemReadyM;
    branch_taken = (hz.PCSrcE == PCSRC_BRANCH) || (hz.PCSrcE == PCSRC_JUMP);
    load_use     = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != '0) &&
                   ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
  end

  // Next state, counter and stall/flush generation; memory wait freezes everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    mdu_busy = (state_q == StMduBusy);

    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (branch_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (hz.MduStartE && (MDU_LATENCY > 1)) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            cnt_d   = MduInit;
            state_d = StMduBusy;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              cnt_d   = LoadInit;
              state_d = StLoadStall;
            end
          end
        end
        StLoadStall: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (cnt_q == '0) state_d = StIdle;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        StMduBusy: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          if (cnt_q == '0) state_d = StIdle;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and shared down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs forced quiet while reset is held, independent of the clock.
  always_comb begin
    hz.StallF    = stall_f & ~rst;
    hz.StallD    = stall_d & ~rst;
    hz.StallE    = stall_e & ~rst;
    hz.StallM    = stall_m & ~rst;
    hz.FlushD    = flush_d & ~rst;
    hz.FlushE    = flush_e & ~rst;
    hz.FlushM    = flush_m & ~rst;
    hz.FlushW    = flush_w & ~rst;
    hz.MduBusy   = mdu_busy & ~rst;
    hz.ForwardAE = rst ? 2'b00 : fwd_a;
    hz.ForwardBE = rst ? 2'b00 : fwd_b;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a remaining-bubble reference model.
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned LB = 2;
  localparam int unsigned ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) hz ();

  hazard_ctrl #(
    .REG_AW       (AW),
    .LOAD_BUBBLES (LB),
    .MDU_LATENCY  (ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bubbles / MDU stall cycles still owed after the current one.
  int load_left = 0;
  int mdu_left  = 0;

  // Last sampled outputs, for directed counting.
  logic [12:0] obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (hz.RegWriteM && rs == hz.RdM) return 2'b10;
    if (hz.RegWriteW && rs == hz.RdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] pack_outs();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM,
            hz.FlushW, hz.ForwardAE, hz.ForwardBE, hz.MduBusy};
  endfunction

  // Expected outputs for this cycle; advances the model to the next cycle.
  task automatic model_eval(output logic [12:0] want);
    logic sf, sd, se, sm, fd, fe, fm, fw, busy;
    logic [1:0] fa, fb;
    {sf, sd, se, sm, fd, fe, fm, fw, busy} = '0;
    fa = 2'b00;
    fb = 2'b00;
    if (rst) begin
      load_left = 0;
      mdu_left  = 0;
    end else begin
      fa   = fwd_ref(hz.Rs1E);
      fb   = fwd_ref(hz.Rs2E);
      busy = (mdu_left > 0);
      if (hz.MemReqM && !hz.MemReadyM) begin
        {sf, sd, se, sm, fw} = '1;
      end else if (mdu_left > 0) begin
        {sf, sd, se, fm} = '1;
        mdu_left--;
      end else if (load_left > 0) begin
        {sf, sd, fe} = '1;
        load_left--;
      end else if (hz.PCSrcE == 2'b01 || hz.PCSrcE == 2'b10) begin
        {fd, fe} = '1;
      end else if (hz.MduStartE && ML > 1) begin
        {sf, sd, se, fm} = '1;
        mdu_left = ML - 1;
      end else if (hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
                   (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE)) begin
        {sf, sd, fe} = '1;
        load_left = LB - 1;
      end
    end
    want = {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, busy};
  endtask

  // One clock: sample at negedge against the model, then move past posedge.
  task automatic cycle(input string tag);
    logic [12:0] want;
    @(negedge clk);
    obs = pack_outs();
    model_eval(want);
    check_eq(tag, 32'(obs), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE = 2'b00; hz.MduStartE = 1'b0; hz.PCSrcE = 2'b00;
    hz.RdM = '0; hz.RegWriteM = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    hz.RdW = '0; hz.RegWriteW = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b;
    idle_inputs();

    // Reset: outputs quiet even with forwarding matches present.
    rst = 1'b1;
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
    cycle("reset_outs");
    check_eq("reset_fwd_a", 32'(hz.ForwardAE), 32'd0);

    // Forwarding priority and x0 exclusion.
    rst = 1'b0;
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    cycle("fwd_m_beats_w");
    check_eq("fwd_a_m", 32'(hz.ForwardAE), 32'h2);
    hz.RegWriteM = 1'b0; hz.Rs2E = 5'd5;
    cycle("fwd_w");
    check_eq("fwd_b_w", 32'(hz.ForwardBE), 32'h1);
    hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0; hz.RegWriteM = 1'b1;
    cycle("fwd_x0");
    check_eq("fwd_a_x0", 32'(hz.ForwardAE), 32'h0);
    idle_inputs();

    // Load-use: exactly LB bubbles.
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    cnt_a = 0;
    cycle("load_use_0");
    cnt_a += int'(obs[11] & obs[7]);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cycle("load_use_n");
      cnt_a += int'(obs[11] & obs[7]);
    end
    check_eq("load_bubbles", 32'(cnt_a), 32'(LB));

    // Load to x0 never stalls.
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    cycle("load_x0");
    check_eq("load_x0_stall", 32'(obs[11]), 32'd0);
    idle_inputs();

    // MDU occupancy.
    hz.MduStartE = 1'b1;
    cnt_a = 0;
    cycle("mdu_start");
    cnt_a += int'(obs[10]);
    hz.MduStartE = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle("mdu_run");
      cnt_a += int'(obs[10]);
    end
    check_eq("mdu_stall_e_cycles", 32'(cnt_a), 32'(ML));

    // MDU stretched by three memory-wait cycles.
    cnt_a = 0;
    cnt_b = 0;
    hz.MduStartE = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) hz.MduStartE = 1'b0;
      hz.MemReqM = (i >= 2 && i <= 4);
      hz.MemReadyM = 1'b0;
      cycle("mdu_memwait");
      cnt_a += int'(obs[10]);
      cnt_b += int'(obs[0]);
      if (i == 3) check_eq("memwait_flush_w", 32'(obs[5]), 32'd1);
    end
    check_eq("mdu_memwait_stall_e", 32'(cnt_a), 32'(ML + 3));
    check_eq("mdu_memwait_busy", 32'(cnt_b), 32'(ML - 1 + 3));
    idle_inputs();

    // Branch beats coincident load-use; no stall afterwards.
    hz.PCSrcE = 2'b01; hz.ResultSrcE = 2'b01; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
    cycle("branch_load");
    check_eq("branch_flush_d", 32'(obs[8]), 32'd1);
    check_eq("branch_no_stall", 32'(obs[11]), 32'd0);
    idle_inputs();
    cycle("after_branch");
    check_eq("after_branch_stall", 32'(obs[11]), 32'd0);
    hz.PCSrcE = 2'b11;
    cycle("pcsrc_11");
    check_eq("pcsrc_11_flush", 32'(obs[8]), 32'd0);
    idle_inputs();

    // Asynchronous reset in the middle of MDU_BUSY.
    hz.MduStartE = 1'b1;
    cycle("mdu_pre_rst");
    hz.MduStartE = 1'b0;
    check_eq("mdu_busy_before_rst", 32'(hz.MduBusy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_async_busy", 32'(hz.MduBusy), 32'd0);
    check_eq("rst_async_stall_e", 32'(hz.StallE), 32'd0);
    load_left = 0;
    mdu_left  = 0;
    cycle("rst_held");
    rst = 1'b0;
    cycle("post_rst_idle");
    check_eq("post_rst_busy", 32'(obs[0]), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      hz.Rs1D       = AW'($urandom_range(0, 7));
      hz.Rs2D       = AW'($urandom_range(0, 7));
      hz.Rs1E       = AW'($urandom_range(0, 7));
      hz.Rs2E       = AW'($urandom_range(0, 7));
      hz.RdE        = AW'($urandom_range(0, 7));
      hz.ResultSrcE = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      hz.MduStartE  = ($urandom_range(0, 9) == 0);
      hz.PCSrcE     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hz.RdM        = AW'($urandom_range(0, 7));
      hz.RegWriteM  = 1'($urandom_range(0, 1));
      hz.MemReqM    = ($urandom_range(0, 4) == 0);
      hz.MemReadyM  = 1'($urandom_range(0, 1));
      hz.RdW        = AW'($urandom_range(0, 7));
      hz.RegWriteW  = 1'($urandom_range(0, 1));
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
